// File: rtl/stoch_col2im_pkg.sv
// Shared sizing helpers and FSM state encoding for the stochastic signed col2im block.
package stoch_col2im_pkg;

  // Frame phases: collecting column rows, then presenting the finished image.
  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_e;

  // Number of window positions along one image axis.
  function automatic int out_w(input int im_w, input int pad_w, input int k_w, input int s_w);
    return (im_w + 2 * pad_w - k_w) / s_w + 1;
  endfunction

  function automatic int out_h(input int im_h, input int pad_h, input int k_h, input int s_h);
    return (im_h + 2 * pad_h - k_h) / s_h + 1;
  endfunction

  // Rows per frame: one per output window.
  function automatic int col_height(input int o_h, input int o_w);
    return o_h * o_w;
  endfunction

  // Bits per column row: one per kernel tap per channel.
  function automatic int col_width(input int k_h, input int k_w, input int ch);
    return k_h * k_w * ch;
  endfunction

  // A pixel collects at most k_h*k_w bits per frame, so this width never overflows.
  function automatic int cnt_w(input int k_h, input int k_w);
    return $clog2(k_h * k_w + 1);
  endfunction

  // Index width that stays at least one bit even for a single-row frame.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stoch_col2im_scatter.sv
// Combinational scatter: turns one column row into per-pixel increments.
// Every (pixel, tap) pair maps to exactly one window row at elaboration time,
// so the runtime logic is just a row-index compare per tap plus a small adder.
module stoch_col2im_scatter
  import stoch_col2im_pkg::*;
#(
  parameter int IM_HEIGHT = 4,
  parameter int IM_WIDTH  = 4,
  parameter int CHANNELS  = 2,
  parameter int KERNEL_H  = 3,
  parameter int KERNEL_W  = 3,
  parameter int PAD_H     = 1,
  parameter int PAD_W     = 1,
  parameter int STRIDE_H  = 1,
  parameter int STRIDE_W  = 1,
  localparam int OUT_W     = out_w(IM_WIDTH, PAD_W, KERNEL_W, STRIDE_W),
  localparam int OUT_H     = out_h(IM_HEIGHT, PAD_H, KERNEL_H, STRIDE_H),
  localparam int COL_H     = col_height(OUT_H, OUT_W),
  localparam int COL_WIDTH = col_width(KERNEL_H, KERNEL_W, CHANNELS),
  localparam int CNT_W     = cnt_w(KERNEL_H, KERNEL_W),
  localparam int ROW_W     = idx_w(COL_H)
) (
  input  logic [ROW_W-1:0]     row_idx,
  input  logic [COL_WIDTH-1:0] col_p,
  input  logic [COL_WIDTH-1:0] col_m,
  output logic [IM_HEIGHT-1:0][IM_WIDTH-1:0][CHANNELS-1:0][CNT_W-1:0] inc_p,
  output logic [IM_HEIGHT-1:0][IM_WIDTH-1:0][CHANNELS-1:0][CNT_W-1:0] inc_m
);

  localparam int TAPS = KERNEL_H * KERNEL_W;

  for (genvar gy = 0; gy < IM_HEIGHT; gy++) begin : g_row
    for (genvar gx = 0; gx < IM_WIDTH; gx++) begin : g_col
      for (genvar gch = 0; gch < CHANNELS; gch++) begin : g_ch
        logic [TAPS-1:0]  tap_p;
        logic [TAPS-1:0]  tap_m;
        logic [CNT_W-1:0] sum_p;
        logic [CNT_W-1:0] sum_m;

        for (genvar gr = 0; gr < KERNEL_H; gr++) begin : g_kr
          for (genvar gc = 0; gc < KERNEL_W; gc++) begin : g_kc
            // Window origin (in padded coordinates) that would put tap (gr,gc) on this pixel.
            localparam int NY   = gy + PAD_H - gr;
            localparam int NX   = gx + PAD_W - gc;
            localparam int OROW = NY / STRIDE_H;
            localparam int OCOL = NX / STRIDE_W;
            localparam bit HIT  = (NY >= 0) && (NX >= 0) &&
                                  (NY % STRIDE_H == 0) && (NX % STRIDE_W == 0) &&
                                  (OROW < OUT_H) && (OCOL < OUT_W);
            if (HIT) begin : g_hit
              localparam int ROW = OROW * OUT_W + OCOL;
              localparam int B   = gc + gr * KERNEL_W + gch * KERNEL_H * KERNEL_W;
              assign tap_p[gr*KERNEL_W+gc] = (row_idx == ROW_W'(ROW)) & col_p[B];
              assign tap_m[gr*KERNEL_W+gc] = (row_idx == ROW_W'(ROW)) & col_m[B];
            end else begin : g_miss
              assign tap_p[gr*KERNEL_W+gc] = 1'b0;
              assign tap_m[gr*KERNEL_W+gc] = 1'b0;
            end
          end
        end

        // Population count of the taps landing on this pixel for the current row.
        always_comb begin
          sum_p = '0;
          sum_m = '0;
          for (int t = 0; t < TAPS; t++) begin
            sum_p = sum_p + CNT_W'(tap_p[t]);
            sum_m = sum_m + CNT_W'(tap_m[t]);
          end
        end

        assign inc_p[gy][gx][gch] = sum_p;
        assign inc_m[gy][gx][gch] = sum_m;
      end
    end
  end

endmodule

// File: rtl/stoch_signed_col2im.sv
// Stochastic signed col2im: scatter-adds column rows back onto image pixels,
// then presents the accumulated plus/minus counts until the consumer takes them.
module stoch_signed_col2im
  import stoch_col2im_pkg::*;
#(
  parameter int IM_HEIGHT = 4,
  parameter int IM_WIDTH  = 4,
  parameter int CHANNELS  = 2,
  parameter int KERNEL_H  = 3,
  parameter int KERNEL_W  = 3,
  parameter int PAD_H     = 1,
  parameter int PAD_W     = 1,
  parameter int STRIDE_H  = 1,
  parameter int STRIDE_W  = 1,
  localparam int OUT_W      = out_w(IM_WIDTH, PAD_W, KERNEL_W, STRIDE_W),
  localparam int OUT_H      = out_h(IM_HEIGHT, PAD_H, KERNEL_H, STRIDE_H),
  localparam int COL_HEIGHT = col_height(OUT_H, OUT_W),
  localparam int COL_WIDTH  = col_width(KERNEL_H, KERNEL_W, CHANNELS),
  localparam int CNT_W      = cnt_w(KERNEL_H, KERNEL_W),
  localparam int ROW_W      = idx_w(COL_HEIGHT)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 col_valid,
  output logic                 col_ready,
  input  logic                 col_last,
  input  logic [COL_WIDTH-1:0] col_p,
  input  logic [COL_WIDTH-1:0] col_m,
  output logic                 im_valid,
  input  logic                 im_ready,
  output logic [IM_HEIGHT-1:0][IM_WIDTH-1:0][CHANNELS-1:0][CNT_W-1:0] im_p,
  output logic [IM_HEIGHT-1:0][IM_WIDTH-1:0][CHANNELS-1:0][CNT_W-1:0] im_m,
  output logic                 frame_err
);

  typedef logic [IM_HEIGHT-1:0][IM_WIDTH-1:0][CHANNELS-1:0][CNT_W-1:0] cnt_t;

  state_e           state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             frame_err_q, frame_err_d;
  cnt_t             cnt_p_q, cnt_p_d;
  cnt_t             cnt_m_q, cnt_m_d;
  cnt_t             inc_p, inc_m;
  logic             accept;
  logic             last_row;

  stoch_col2im_scatter #(
    .IM_HEIGHT (IM_HEIGHT),
    .IM_WIDTH  (IM_WIDTH),
    .CHANNELS  (CHANNELS),
    .KERNEL_H  (KERNEL_H),
    .KERNEL_W  (KERNEL_W),
    .PAD_H     (PAD_H),
    .PAD_W     (PAD_W),
    .STRIDE_H  (STRIDE_H),
    .STRIDE_W  (STRIDE_W)
  ) u_scatter (
    .row_idx (row_q),
    .col_p   (col_p),
    .col_m   (col_m),
    .inc_p   (inc_p),
    .inc_m   (inc_m)
  );

  assign col_ready = (state_q == ACCUM);
  assign im_valid  = (state_q == DONE);
  assign accept    = col_valid & col_ready;
  assign last_row  = (row_q == ROW_W'(COL_HEIGHT - 1));
  assign im_p      = cnt_p_q;
  assign im_m      = cnt_m_q;
  assign frame_err = frame_err_q;

  // Next-state: accumulate on accept, advance the row count, clear on image hand-off.
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    frame_err_d = frame_err_q;
    cnt_p_d     = cnt_p_q;
    cnt_m_d     = cnt_m_q;
    if (accept) begin
      for (int y = 0; y < IM_HEIGHT; y++) begin
        for (int x = 0; x < IM_WIDTH; x++) begin
          for (int c = 0; c < CHANNELS; c++) begin
            cnt_p_d[y][x][c] = cnt_p_q[y][x][c] + inc_p[y][x][c];
            cnt_m_d[y][x][c] = cnt_m_q[y][x][c] + inc_m[y][x][c];
          end
        end
      end
      // The sender's framing is only reported; the internal count decides the frame end.
      if (col_last != last_row) begin
        frame_err_d = 1'b1;
      end
      if (last_row) begin
        state_d = DONE;
        row_d   = '0;
      end else begin
        row_d = row_q + ROW_W'(1);
      end
    end else if ((state_q == DONE) && im_ready) begin
      cnt_p_d = '0;
      cnt_m_d = '0;
      state_d = ACCUM;
    end
  end

  // State, row counter, pixel counters and sticky error flag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ACCUM;
      row_q       <= '0;
      frame_err_q <= 1'b0;
      cnt_p_q     <= '0;
      cnt_m_q     <= '0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      frame_err_q <= frame_err_d;
      cnt_p_q     <= cnt_p_d;
      cnt_m_q     <= cnt_m_d;
    end
  end

endmodule
